// File: rtl/imem_rd_responder.sv
// Instruction-memory read responder: AXI4-Lite read slave in front of a
// backdoor-loaded word array, with a fixed number of access cycles per fetch.
module imem_rd_responder #(
    parameter  int XLEN        = 32,
    parameter  int DEPTH_WORDS = 4096,
    parameter  int WAIT_CYCLES = 0,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic            ACLK,
    input  logic            ARESETn,
    input  logic [XLEN-1:0] ARADDR,
    input  logic            ARVALID,
    output logic            ARREADY,
    output logic [XLEN-1:0] RDATA,
    output logic [1:0]      RRESP,
    output logic            RVALID,
    input  logic            RREADY,
    input  logic            mem_we,
    input  logic [AW-1:0]   mem_waddr,
    input  logic [XLEN-1:0] mem_wdata,
    output logic [1:0]      dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0]      RESP_OKAY   = 2'b00;
    localparam logic [1:0]      RESP_SLVERR = 2'b10;
    localparam logic [1:0]      RESP_DECERR = 2'b11;
    localparam logic [3:0]      CNT_INIT    = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic [XLEN-3:0] DEPTH_LIM   = (XLEN-2)'(DEPTH_WORDS);

    state_t          state_q;
    logic            arready_q;
    logic            rvalid_q;
    logic [XLEN-1:0] rdata_q;
    logic [1:0]      rresp_q;
    logic [XLEN-1:0] addr_q;
    logic [3:0]      cnt_q;

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];

    logic [XLEN-1:0] resp_addr;
    logic [XLEN-3:0] word_idx;
    logic [XLEN-1:0] rdata_d;
    logic [1:0]      rresp_d;

    // Program image: no reset, so contents survive ARESETn.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Response decode. The array read is combinational and sampled at the
    // registering edge, so a same-edge backdoor write yields the old word.
    always_comb begin
        resp_addr = (state_q == IDLE) ? ARADDR : addr_q;
        word_idx  = resp_addr[XLEN-1:2];
        rdata_d   = '0;
        rresp_d   = RESP_OKAY;
        if (resp_addr[1:0] != 2'b00) begin
            rresp_d = RESP_SLVERR;
        end else if (word_idx >= DEPTH_LIM) begin
            rresp_d = RESP_DECERR;
        end else begin
            rdata_d = mem_q[word_idx[AW-1:0]];
        end
    end

    // Valid/ready: AR handshake is ARVALID && ARREADY at a rising edge (only
    // possible in IDLE); R handshake is RVALID && RREADY, after which RDATA/RRESP
    // may change. All outputs are registered.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            addr_q    <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ARVALID && arready_q) begin
                        addr_q    <= ARADDR;
                        arready_q <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            rdata_q  <= rdata_d;
                            rresp_q  <= rresp_d;
                            rvalid_q <= 1'b1;
                            state_q  <= RESP;
                        end else begin
                            cnt_q   <= CNT_INIT;
                            state_q <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        rdata_q  <= rdata_d;
                        rresp_q  <= rresp_d;
                        rvalid_q <= 1'b1;
                        state_q  <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (RREADY) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ARREADY     = arready_q;
    assign RVALID      = rvalid_q;
    assign RDATA       = rdata_q;
    assign RRESP       = rresp_q;
    assign dbg_state_o = state_q;

endmodule
